frame_state_buffer: RTL and testbench
=====================================

Name: frame_state_buffer

Overview:
- Double-buffered register file between the CPU memory-mapped write path and the VGA display controller.
- The CPU writes bullet, sprite and health words into a shadow bank at any time.
- The display bank feeds the controller's packed buses and updates only at a frame boundary, after the CPU has marked the frame complete. This prevents tearing.

Parameters:
- MAX_BULLETS, 64, number of 32-bit bullet slots.
- NUM_SPRITE_WORDS, 4, sprite words in order x1, y1, x2, y2.
- NUM_HEALTH_WORDS, 2, health words in order p1, p2.
- ADDR_WIDTH, 7, word address width.

Ports:
- clk  input  1  system clock, same clock as the display controller.
- reset  input  1  synchronous, active-high reset.
- screenEnd  input  1  one-cycle pulse between frames, from the timing generator.
- wEn  input  1  CPU write strobe.
- addr  input  ADDR_WIDTH  CPU word address.
- dataIn  input  32  CPU write data.
- dataOut  output  32  shadow-bank read data for addr, registered.
- allBulletContents  output  32*MAX_BULLETS  display bank, bullet j at bits [j*32 +: 32].
- allSpriteContents  output  32*NUM_SPRITE_WORDS  display bank, word i at bits [i*32 +: 32].
- allHealthContents  output  32*NUM_HEALTH_WORDS  display bank, p1 at [31:0], p2 at [63:32].
- commitPending  output  1  frame-ready flag is set and waiting for screenEnd.
- frameCount  output  16  number of commits since reset.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
  - On reset, both banks, dataOut, commitPending and frameCount are cleared to 0.
  - Reset has priority over every other input in the same cycle.
- Address map (word addresses):
  - 0..63: bullet slots.
  - 64..67: sprite words.
  - 68..69: health words.
  - 70: FRAME_READY control.
  - 71..127: reserved. Writes are ignored; reads return 0.
- Bullet word format, as consumed by the display controller:
  - [31:22] x.
  - [21:13] y.
  - [2] active.
  - Other bits are stored verbatim and not interpreted.
- Writes: when wEn=1 and addr<70, dataIn is stored into the shadow word on the next rising edge.
- FRAME_READY: when wEn=1 and addr==70, the write sets commitPending on the next edge. dataIn is ignored.
- Reads:
  - dataOut = shadow[addr], registered, so latency is one cycle.
  - addr==70 returns {31'b0, commitPending}.
- State machine, two states:
  - IDLE (commitPending=0) goes to ARMED on a FRAME_READY write.
  - ARMED (commitPending=1) goes to IDLE on a screenEnd cycle. In that edge, every display word takes its shadow word and frameCount increments.
  - ARMED plus another FRAME_READY write stays ARMED. Writes are idempotent.
- screenEnd while IDLE: no commit; the display bank holds its value and frameCount is unchanged.
- Simultaneous data write and commit (wEn, addr<70, screenEnd, ARMED):
  - The display bank receives the post-write value (write-through).
  - The shadow bank also takes the write.
- Simultaneous FRAME_READY write and screenEnd while IDLE: commitPending sets; no commit this frame.
- Simultaneous FRAME_READY write and screenEnd while ARMED: the commit occurs and commitPending ends at 1 (re-armed).
- frameCount wraps from 0xFFFF to 0x0000.
- Display outputs are driven directly from the display-bank registers. They never change except on a commit edge or reset.
- Reset mid-frame while ARMED: the pending commit is discarded and the display bank is cleared.

Test Plan:
- Reset: assert reset for 2 cycles. Required: all buses 0, commitPending=0, frameCount=0, dataOut=0.
- Deferred commit:
  - Write bullet 5 = 0x0C81_4004 (x=50, y=10, active). Required: allBulletContents[191:160] stays 0.
  - Write addr 70, then pulse screenEnd. Required: the slot reads 0x0C81_4004 one cycle after the screenEnd edge, frameCount=1, commitPending=0.
- No commit without ready: write sprite word 64 = 100, pulse screenEnd twice without a FRAME_READY write. Required: allSpriteContents[31:0] stays 0 and frameCount is unchanged.
- Write/commit collision: with ARMED set, write health 68 = 75 in the same cycle as screenEnd. Required: allHealthContents[31:0]=75 after that edge, and dataOut for addr 68 reads 75.
- Readback and reserved space:
  - Write addr 69 = 0xDEAD_BEEF, then read it. Required: dataOut=0xDEAD_BEEF one cycle later.
  - Write addr 100 = 0x1234. Required: reading addr 100 returns 0 and no bank changes.
- Reset while armed: set FRAME_READY, then assert reset before screenEnd. Required: commitPending=0; a later screenEnd leaves all buses 0.

Source files
------------

// File: rtl/frame_state_buffer.sv
// ============================================================================
// Module   : frame_state_buffer
// Purpose  : Double-buffered CPU/VGA register file with frame-boundary commit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_state_buffer #(
  parameter int MAX_BULLETS      = 64,
  parameter int NUM_SPRITE_WORDS = 4,
  parameter int NUM_HEALTH_WORDS = 2,
  parameter int ADDR_WIDTH       = 7
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            screenEnd,
  input  logic                            wEn,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [31:0]                     dataIn,
  output logic [31:0]                     dataOut,
  output logic [32*MAX_BULLETS-1:0]       allBulletContents,
  output logic [32*NUM_SPRITE_WORDS-1:0]  allSpriteContents,
  output logic [32*NUM_HEALTH_WORDS-1:0]  allHealthContents,
  output logic                            commitPending,
  output logic [15:0]                     frameCount
);

  localparam int NUM_WORDS = MAX_BULLETS + NUM_SPRITE_WORDS + NUM_HEALTH_WORDS;
  localparam logic [ADDR_WIDTH-1:0] c_frame_ready_addr = ADDR_WIDTH'(NUM_WORDS);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ARMED = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_state_next;
  logic        w_commit;
  logic        w_data_wr;
  logic        w_ready_wr;
  logic [31:0] r_shadow  [NUM_WORDS];
  logic [31:0] r_display [NUM_WORDS];
  logic [31:0] r_data_out;
  logic [15:0] r_frame_count;

  assign w_data_wr  = wEn && (addr < c_frame_ready_addr);
  assign w_ready_wr = wEn && (addr == c_frame_ready_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A FRAME_READY write on the commit edge re-arms for the following frame.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ready_wr) w_state_next = S_ARMED;
      end
      S_ARMED: begin
        if (screenEnd && !w_ready_wr) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    commitPending = 1'b0;
    w_commit      = 1'b0;
    case (r_state)
      S_ARMED: begin
        commitPending = 1'b1;
        w_commit      = screenEnd;
      end
      default: begin
        commitPending = 1'b0;
        w_commit      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) r_shadow[i] <= 32'd0;
    end else if (w_data_wr) begin
      r_shadow[addr] <= dataIn;
    end
  end

  // A write landing on the commit edge goes straight through to the display.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) r_display[i] <= 32'd0;
    end else if (w_commit) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        r_display[i] <= (w_data_wr && (addr == ADDR_WIDTH'(i))) ? dataIn : r_shadow[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_count <= 16'd0;
    end else if (w_commit) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= 32'd0;
    end else if (addr < c_frame_ready_addr) begin
      r_data_out <= r_shadow[addr];
    end else if (addr == c_frame_ready_addr) begin
      r_data_out <= {31'd0, commitPending};
    end else begin
      r_data_out <= 32'd0;
    end
  end

  assign dataOut    = r_data_out;
  assign frameCount = r_frame_count;

  for (genvar j = 0; j < MAX_BULLETS; j++) begin : g_bullet
    assign allBulletContents[j*32 +: 32] = r_display[j];
  end

  for (genvar j = 0; j < NUM_SPRITE_WORDS; j++) begin : g_sprite
    assign allSpriteContents[j*32 +: 32] = r_display[MAX_BULLETS + j];
  end

  for (genvar j = 0; j < NUM_HEALTH_WORDS; j++) begin : g_health
    assign allHealthContents[j*32 +: 32] = r_display[MAX_BULLETS + NUM_SPRITE_WORDS + j];
  end

endmodule

`default_nettype wire

// File: tb/tb_frame_state_buffer.sv
// ============================================================================
// Module   : tb_frame_state_buffer
// Purpose  : Directed self-checking bench for frame_state_buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_state_buffer;

  logic             clk = 1'b0;
  logic             reset;
  logic             screenEnd;
  logic             wEn;
  logic [6:0]       addr;
  logic [31:0]      dataIn;
  logic [31:0]      dataOut;
  logic [2047:0]    allBulletContents;
  logic [127:0]     allSpriteContents;
  logic [63:0]      allHealthContents;
  logic             commitPending;
  logic [15:0]      frameCount;

  int n_vec = 0;
  int n_err = 0;

  frame_state_buffer dut (
    .clk               (clk),
    .reset             (reset),
    .screenEnd         (screenEnd),
    .wEn               (wEn),
    .addr              (addr),
    .dataIn            (dataIn),
    .dataOut           (dataOut),
    .allBulletContents (allBulletContents),
    .allSpriteContents (allSpriteContents),
    .allHealthContents (allHealthContents),
    .commitPending     (commitPending),
    .frameCount        (frameCount)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    wEn = 1'b1; addr = a; dataIn = d;
    step();
    wEn = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bullets"}, {31'd0, |allBulletContents}, 32'd0);
    chk({tag, "_sprites"}, {31'd0, |allSpriteContents}, 32'd0);
    chk({tag, "_health"},  {31'd0, |allHealthContents}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; screenEnd = 1'b0; wEn = 1'b0; addr = 7'd0; dataIn = 32'd0;
    step();
    step();
    reset = 1'b0;
    chk_all_zero("reset");
    chk("reset_pending", {31'd0, commitPending}, 32'd0);
    chk("reset_fcount", {16'd0, frameCount}, 32'd0);
    chk("reset_dout", dataOut, 32'd0);

    // Deferred commit of bullet 5
    wr(7'd5, 32'h0C81_4004);
    chk("b5_before_ready", allBulletContents[191:160], 32'd0);
    wr(7'd70, 32'hFFFF_FFFF);
    chk("armed_pending", {31'd0, commitPending}, 32'd1);
    chk("b5_armed", allBulletContents[191:160], 32'd0);
    screenEnd = 1'b1; step(); screenEnd = 1'b0;
    chk("b5_committed", allBulletContents[191:160], 32'h0C81_4004);
    chk("commit1_fcount", {16'd0, frameCount}, 32'd1);
    chk("commit1_pending", {31'd0, commitPending}, 32'd0);
    addr = 7'd5; step();
    chk("b5_readback", dataOut, 32'h0C81_4004);

    // screenEnd without FRAME_READY does nothing
    wr(7'd64, 32'd100);
    screenEnd = 1'b1; step(); step(); screenEnd = 1'b0;
    chk("nocommit_sprite", allSpriteContents[31:0], 32'd0);
    chk("nocommit_fcount", {16'd0, frameCount}, 32'd1);
    chk("nocommit_pending", {31'd0, commitPending}, 32'd0);

    // Write colliding with commit: write-through to display
    wr(7'd70, 32'd0);
    wEn = 1'b1; addr = 7'd68; dataIn = 32'd75; screenEnd = 1'b1;
    step();
    wEn = 1'b0; screenEnd = 1'b0;
    chk("collide_health", allHealthContents[31:0], 32'd75);
    chk("collide_sprite", allSpriteContents[31:0], 32'd100);
    chk("collide_fcount", {16'd0, frameCount}, 32'd2);
    chk("collide_pending", {31'd0, commitPending}, 32'd0);
    step();
    chk("collide_readback", dataOut, 32'd75);

    // Readback and reserved space
    wr(7'd69, 32'hDEAD_BEEF);
    addr = 7'd69; step();
    chk("h2_readback", dataOut, 32'hDEAD_BEEF);
    chk("h2_not_displayed", allHealthContents[63:32], 32'd0);
    wr(7'd100, 32'h0000_1234);
    addr = 7'd100; step();
    chk("reserved_read", dataOut, 32'd0);
    chk("reserved_b5", allBulletContents[191:160], 32'h0C81_4004);
    chk("reserved_pending", {31'd0, commitPending}, 32'd0);
    addr = 7'd70; step();
    chk("ready_read_idle", dataOut, 32'd0);

    // Reset while armed discards the commit
    wr(7'd70, 32'd1);
    addr = 7'd70; step();
    chk("ready_read_armed", dataOut, 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_armed_pending", {31'd0, commitPending}, 32'd0);
    chk("rst_armed_fcount", {16'd0, frameCount}, 32'd0);
    chk("rst_armed_dout", dataOut, 32'd0);
    screenEnd = 1'b1; step(); screenEnd = 1'b0;
    chk_all_zero("post_rst_screenend");
    chk("post_rst_fcount", {16'd0, frameCount}, 32'd0);

    // FRAME_READY together with screenEnd: idle arms only, armed commits and re-arms
    wr(7'd0, 32'hAAAA_5555);
    wEn = 1'b1; addr = 7'd70; screenEnd = 1'b1;
    step();
    chk("idle_ready_se_pending", {31'd0, commitPending}, 32'd1);
    chk("idle_ready_se_fcount", {16'd0, frameCount}, 32'd0);
    chk("idle_ready_se_b0", allBulletContents[31:0], 32'd0);
    step();
    wEn = 1'b0; screenEnd = 1'b0;
    chk("rearm_b0", allBulletContents[31:0], 32'hAAAA_5555);
    chk("rearm_fcount", {16'd0, frameCount}, 32'd1);
    chk("rearm_pending", {31'd0, commitPending}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
